sd_cmd_sequencer: RTL and testbench

Sequences SD-card SPI-mode command transactions on top of `spi_controller`. It accepts a command index and argument, builds the 6-byte frame in its own byte buffer, and starts a write transfer. It then polls the card one byte at a time until a valid R1 response arrives or the poll limit expires. It owns the buffer that `spi_controller` addresses, and sits between the card-init/block-access logic and the SPI datapath.

---
 rtl/sd_cmd_sequencer_pkg.sv | 36 +++
 rtl/sd_cmd_sequencer_crc7.sv | 31 +++
 rtl/sd_cmd_sequencer.sv | 173 +++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared types and constants for the SD SPI-mode command sequencer.
// Holds the FSM state enum, frame constants and a byte-serial CRC7 step.
package sd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_TX,
    S_POLL,
    S_WAIT_RX,
    S_CHECK,
    S_RESP
  } sd_state_t;

  localparam int         SD_FRAME_BYTES  = 6;
  localparam logic [7:0] SD_R1_IDLE_BYTE = 8'hFF;
  localparam logic [7:0] SD_DEFAULT_CRC  = 8'h95;

  // CRC7 (x^7 + x^3 + 1), one byte folded in MSB first.
  function automatic logic [6:0] crc7_byte(
    input logic [6:0] crc,
    input logic [7:0] data
  );
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_crc7.sv
// sd_crc7: byte-serial CRC7 accumulator for SD command frames.
// Ports: clk, rst (async high), clr (restart at 0), en (fold data), data[7:0], crc[6:0].
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] seed;

  // clr together with en starts a new frame with this byte as its first.
  assign seed = clr ? 7'h00 : crc_q;
  assign crc  = crc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 7'h00;
    end else if (en) begin
      crc_q <= crc7_byte(seed, data);
    end else if (clr) begin
      crc_q <= 7'h00;
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: builds a 6-byte SD command frame, sends it through spi_controller,
// then polls single bytes for an R1 response. Macro SD_CRC7_EN enables real CRC7.
// Ports: cmd_* request, rsp_* result, spi_* controller handshake and buffer port.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter  int MEMORY_SIZE_IN_BYTES = 10,
  parameter  int NCR_MAX              = 8,
  localparam int AW                   = $clog2(MEMORY_SIZE_IN_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [5:0]    cmd_index,
  input  logic [31:0]   cmd_arg,
  output logic          rsp_valid,
  output logic [7:0]    rsp_r1,
  output logic          rsp_timeout,
  output logic          spi_start,
  output logic          spi_op,
  output logic [AW-1:0] spi_size,
  input  logic          spi_done,
  input  logic [AW-1:0] spi_address,
  output logic [7:0]    spi_data_out,
  input  logic [7:0]    spi_data_in,
  input  logic          spi_wr
);

  sd_state_t state, nxt;

  logic [7:0]    mem [SD_FRAME_BYTES];
  logic [31:0]   arg_q;
  logic [2:0]    load_cnt;
  logic [7:0]    poll_cnt;
  logic [7:0]    r1_q;
  logic          to_q;
  logic          op_q, op_d;
  logic [AW-1:0] size_q, size_d;
  logic [7:0]    arg_byte;
  logic [7:0]    crc_byte;
  logic          poll_last;
  logic          in_frame;

  assign poll_last = (poll_cnt + 8'd1) == 8'(NCR_MAX);
  assign in_frame  = spi_address < AW'(SD_FRAME_BYTES);

  always_comb begin
    case (load_cnt)
      3'd1:    arg_byte = arg_q[31:24];
      3'd2:    arg_byte = arg_q[23:16];
      3'd3:    arg_byte = arg_q[15:8];
      default: arg_byte = arg_q[7:0];
    endcase
  end

`ifdef SD_CRC7_EN
  logic       crc_clr;
  logic       crc_en;
  logic [7:0] crc_data;
  logic [6:0] crc;

  // Byte 0 is folded in on the accept cycle, bytes 1-4 during LOAD.
  assign crc_clr  = (state == S_IDLE) && cmd_valid;
  assign crc_en   = crc_clr || ((state == S_LOAD) && (load_cnt != 3'd5));
  assign crc_data = crc_clr ? {2'b01, cmd_index} : arg_byte;
  assign crc_byte = {crc, 1'b1};

  sd_crc7 u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (crc_data),
    .crc  (crc)
  );
`else
  assign crc_byte = SD_DEFAULT_CRC;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    spi_start = 1'b0;
    op_d      = op_q;
    size_d    = size_q;
    unique case (state)
      S_IDLE:    if (cmd_valid) nxt = S_LOAD;
      S_LOAD:    if (load_cnt == 3'd5) nxt = S_SEND;
      S_SEND: begin
        spi_start = 1'b1;
        op_d      = 1'b1;
        size_d    = AW'(SD_FRAME_BYTES);
        nxt       = S_WAIT_TX;
      end
      S_WAIT_TX: if (spi_done) nxt = S_POLL;
      S_POLL: begin
        spi_start = 1'b1;
        op_d      = 1'b0;
        size_d    = AW'(1);
        nxt       = S_WAIT_RX;
      end
      S_WAIT_RX: if (spi_done) nxt = S_CHECK;
      S_CHECK: begin
        if (!mem[0][7] || poll_last) nxt = S_RESP;
        else                         nxt = S_POLL;
      end
      S_RESP:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SD_FRAME_BYTES; i++) mem[i] <= SD_R1_IDLE_BYTE;
      arg_q    <= '0;
      load_cnt <= '0;
      poll_cnt <= '0;
      r1_q     <= SD_R1_IDLE_BYTE;
      to_q     <= 1'b0;
      op_q     <= 1'b0;
      size_q   <= '0;
    end else begin
      op_q   <= op_d;
      size_q <= size_d;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            arg_q    <= cmd_arg;
            mem[0]   <= {2'b01, cmd_index};
            load_cnt <= 3'd1;
            r1_q     <= SD_R1_IDLE_BYTE;
            to_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_cnt == 3'd5) mem[5] <= crc_byte;
          else                  mem[load_cnt] <= arg_byte;
          load_cnt <= load_cnt + 3'd1;
        end
        S_WAIT_TX: if (spi_done) poll_cnt <= '0;
        // A poll that never writes back must read as busy.
        S_POLL:    mem[0] <= SD_R1_IDLE_BYTE;
        S_CHECK: begin
          if (!mem[0][7]) begin
            r1_q <= mem[0];
          end else begin
            poll_cnt <= poll_cnt + 8'd1;
            if (poll_last) begin
              r1_q <= SD_R1_IDLE_BYTE;
              to_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (spi_wr && in_frame) mem[spi_address[2:0]] <= spi_data_in;
    end
  end

  assign spi_data_out = in_frame ? mem[spi_address[2:0]] : 8'hFF;
  assign spi_op       = op_d;
  assign spi_size     = size_d;
  assign cmd_ready    = (state == S_IDLE);
  assign rsp_valid    = (state == S_RESP);
  assign rsp_r1       = r1_q;
  assign rsp_timeout  = to_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed self-checking bench for sd_cmd_sequencer with a behavioural SPI controller.
// Card replies come from a per-test table; -1 means the controller never writes back.
module tb_sd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        rsp_valid;
  logic [7:0]  rsp_r1;
  logic        rsp_timeout;
  logic        spi_start;
  logic        spi_op;
  logic [3:0]  spi_size;
  logic        spi_done;
  logic [3:0]  spi_address;
  logic [7:0]  spi_data_out;
  logic [7:0]  spi_data_in;
  logic        spi_wr;

  int total = 0;
  int bad   = 0;
  int card [16];

  always #5 clk = ~clk;

  sd_cmd_sequencer #(
    .MEMORY_SIZE_IN_BYTES (10),
    .NCR_MAX              (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .rsp_valid    (rsp_valid),
    .rsp_r1       (rsp_r1),
    .rsp_timeout  (rsp_timeout),
    .spi_start    (spi_start),
    .spi_op       (spi_op),
    .spi_size     (spi_size),
    .spi_done     (spi_done),
    .spi_address  (spi_address),
    .spi_data_out (spi_data_out),
    .spi_data_in  (spi_data_in),
    .spi_wr       (spi_wr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_card(input int b0, input int b1, input int b2);
    for (int i = 0; i < 16; i++) card[i] = 8'hFF;
    card[0] = b0;
    card[1] = b1;
    card[2] = b2;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run(
    input  bit          inject,
    output logic [47:0] frame,
    output int          tx_cyc,
    output int          gap,
    output int          npolls,
    output int          ntx,
    output logic [7:0]  r1,
    output logic        to,
    output bit          got
  );
    int done_cyc;
    frame = '0; tx_cyc = -1; gap = -1; npolls = 0; ntx = 0;
    r1 = '0; to = 1'b0; got = 1'b0; done_cyc = -1;
    for (int cyc = 1; cyc <= 400 && !got; cyc++) begin
      @(negedge clk);
      spi_done = 1'b0;
      spi_wr   = 1'b0;
      if (rsp_valid) begin
        r1  = rsp_r1;
        to  = rsp_timeout;
        got = 1'b1;
      end else if (spi_start && spi_op) begin
        ntx++;
        if (tx_cyc < 0) tx_cyc = cyc;
        for (int i = 0; i < 6; i++) begin
          spi_address = 4'(i);
          #1;
          frame = {frame[39:0], spi_data_out};
        end
        @(negedge clk);
        cyc++;
        if (inject) begin
          chk("tx_op_hold", spi_op, 1);
          chk("tx_size_hold", spi_size, 6);
          cmd_valid = 1'b1;
          cmd_index = 6'd17;
          cmd_arg   = 32'h0000_0200;
          #1;
          chk("busy_not_ready", cmd_ready, 0);
          @(negedge clk);
          cyc++;
          cmd_valid = 1'b0;
        end
        spi_done = 1'b1;
        done_cyc = cyc;
      end else if (spi_start) begin
        npolls++;
        if (gap < 0) gap = cyc - done_cyc;
        @(negedge clk);
        cyc++;
        if (npolls <= 16 && card[npolls-1] >= 0) begin
          spi_address = 4'd0;
          spi_data_in = 8'(card[npolls-1]);
          spi_wr      = 1'b1;
        end
        @(negedge clk);
        cyc++;
        spi_wr   = 1'b0;
        spi_done = 1'b1;
      end
    end
    @(negedge clk);
    spi_done = 1'b0;
    spi_wr   = 1'b0;
  endtask

  logic [47:0] frame;
  int          tx_cyc, gap, npolls, ntx;
  logic [7:0]  r1;
  logic        to;
  bit          got;
  bit          seen;
  bit          any_rsp, any_start;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0;
    spi_done = 1'b0; spi_address = '0; spi_data_in = '0; spi_wr = 1'b0;
    set_card(8'hFF, 8'hFF, 8'hFF);

    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_r1", rsp_r1, 8'hFF);
    chk("rst_timeout", rsp_timeout, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_op", spi_op, 0);
    chk("rst_size", spi_size, 0);
    chk("rst_buf0", spi_data_out, 8'hFF);
    spi_address = 4'd9;
    #1;
    chk("buf_oob", spi_data_out, 8'hFF);
    spi_address = 4'd0;
    rst = 1'b0;

    // CMD0, card answers 0x01 on first poll
    set_card(8'h01, 8'hFF, 8'hFF);
    issue(6'd0, 32'h0);
    run(1'b0, frame, tx_cyc, gap, npolls, ntx, r1, to, got);
    chk("cmd0_got", got, 1);
    chk("cmd0_frame", frame, 48'h40_00_00_00_00_95);
    chk("cmd0_tx_cyc", tx_cyc, 5);
    chk("cmd0_poll_gap", gap, 1);
    chk("cmd0_polls", npolls, 1);
    chk("cmd0_r1", r1, 8'h01);
    chk("cmd0_to", to, 0);
    chk("cmd0_valid_pulse", rsp_valid, 0);
    chk("cmd0_ready", cmd_ready, 1);
    chk("cmd0_r1_hold", rsp_r1, 8'h01);

    // CMD8 with check pattern
    set_card(8'h01, 8'hFF, 8'hFF);
    issue(6'd8, 32'h0000_01AA);
    run(1'b0, frame, tx_cyc, gap, npolls, ntx, r1, to, got);
    chk("cmd8_got", got, 1);
`ifdef SD_CRC7_EN
    chk("cmd8_frame", frame, 48'h48_00_00_01_AA_87);
`else
    chk("cmd8_frame", frame, 48'h48_00_00_01_AA_95);
`endif
    chk("cmd8_r1", r1, 8'h01);

    // Busy twice then ready
    set_card(8'hFF, 8'hFF, 8'h00);
    issue(6'd55, 32'h0);
    run(1'b0, frame, tx_cyc, gap, npolls, ntx, r1, to, got);
    chk("busy3_got", got, 1);
    chk("busy3_polls", npolls, 3);
    chk("busy3_r1", r1, 8'h00);
    chk("busy3_to", to, 0);

    // Card never answers
    set_card(8'hFF, 8'hFF, 8'hFF);
    issue(6'd41, 32'h4000_0000);
    run(1'b0, frame, tx_cyc, gap, npolls, ntx, r1, to, got);
    chk("tmo_got", got, 1);
    chk("tmo_frame", frame[47:8], 40'h69_40_00_00_00);
    chk("tmo_polls", npolls, 8);
    chk("tmo_r1", r1, 8'hFF);
    chk("tmo_to", to, 1);
    chk("tmo_to_hold", rsp_timeout, 1);

    // Controller skips write-back on first two polls
    set_card(-1, -1, 8'h05);
    issue(6'd0, 32'h0);
    run(1'b0, frame, tx_cyc, gap, npolls, ntx, r1, to, got);
    chk("nowr_got", got, 1);
    chk("nowr_polls", npolls, 3);
    chk("nowr_r1", r1, 8'h05);
    chk("nowr_to_clr", to, 0);

    // CMD17 request while CMD0 is transmitting
    set_card(8'h01, 8'hFF, 8'hFF);
    issue(6'd0, 32'h0);
    run(1'b1, frame, tx_cyc, gap, npolls, ntx, r1, to, got);
    chk("inj_got", got, 1);
    chk("inj_ntx", ntx, 1);
    chk("inj_frame", frame, 48'h40_00_00_00_00_95);
    chk("inj_r1", r1, 8'h01);
    any_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_start |= spi_start;
    end
    chk("inj_no_queue", any_start, 0);

    // Reset during WAIT_RX
    issue(6'd0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (spi_start) seen = 1'b1;
    end
    chk("rst_tx_seen", seen, 1);
    @(negedge clk);
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    chk("rst_poll_start", spi_start & ~spi_op, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_ready", cmd_ready, 1);
    chk("rstmid_start", spi_start, 0);
    @(negedge clk);
    rst = 1'b0;
    any_rsp = 1'b0;
    any_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      any_rsp   |= rsp_valid;
      any_start |= spi_start;
    end
    chk("rstmid_no_rsp", any_rsp, 0);
    chk("rstmid_no_start", any_start, 0);

    set_card(8'h01, 8'hFF, 8'hFF);
    issue(6'd0, 32'h0);
    run(1'b0, frame, tx_cyc, gap, npolls, ntx, r1, to, got);
    chk("after_rst_got", got, 1);
    chk("after_rst_frame", frame, 48'h40_00_00_00_00_95);
    chk("after_rst_r1", r1, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
